// File: rtl/cplx_result_demux_if.sv
// cplx_result_demux_if: valid/ready bundle for the complex-result demux.
// The slave modport is the demux side; the master modport is the source/consumer side.
interface cplx_result_demux_if #(
    parameter int W     = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [W-1:0]     in_re;
    logic [W-1:0]     in_im;
    logic             out0_valid;
    logic             out0_ready;
    logic [W-1:0]     out0_re;
    logic [W-1:0]     out0_im;
    logic             out1_valid;
    logic             out1_ready;
    logic [W-1:0]     out1_re;
    logic [W-1:0]     out1_im;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid, in_sel, in_re, in_im, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_re, out0_im,
               out1_valid, out1_re, out1_im, cnt0, cnt1
    );

    modport master (
        output in_valid, in_sel, in_re, in_im, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_re, out0_im,
               out1_valid, out1_re, out1_im, cnt0, cnt1
    );
endinterface

// File: rtl/cplx_result_demux.sv
// cplx_result_demux: registered 1-to-2 valid/ready demux for complex results with per-output delivery counters.
// Define DEMUX_RR_EN to steer by an internal round-robin pointer instead of in_sel.
module cplx_result_demux #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    cplx_result_demux_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_st0, r_st1;
    logic [W-1:0]     r_re0, r_im0, r_re1, r_im1;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;
    logic             w_dest, w_acc, w_ld0, w_ld1, w_dlv0, w_dlv1;

`ifdef DEMUX_RR_EN
    logic r_ptr;
    assign w_dest = r_ptr;
    // The pointer never skips a stalled output; the source simply waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= 1'b0;
        else if (w_acc) r_ptr <= ~r_ptr;
    end
`else
    assign w_dest = bus.in_sel;
`endif

    assign bus.in_ready = w_dest ? (r_st1 == EMPTY || bus.out1_ready)
                                 : (r_st0 == EMPTY || bus.out0_ready);
    assign w_acc  = bus.in_valid & bus.in_ready;
    assign w_ld0  = w_acc & ~w_dest;
    assign w_ld1  = w_acc & w_dest;
    assign w_dlv0 = (r_st0 == FULL) & bus.out0_ready;
    assign w_dlv1 = (r_st1 == FULL) & bus.out1_ready;

    // A reload in the delivery cycle keeps the register FULL with the new item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st0  <= EMPTY;
            r_st1  <= EMPTY;
            r_re0  <= '0;
            r_im0  <= '0;
            r_re1  <= '0;
            r_im1  <= '0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            r_st0  <= w_ld0 ? FULL : w_dlv0 ? EMPTY : r_st0;
            r_st1  <= w_ld1 ? FULL : w_dlv1 ? EMPTY : r_st1;
            r_re0  <= w_ld0 ? bus.in_re : r_re0;
            r_im0  <= w_ld0 ? bus.in_im : r_im0;
            r_re1  <= w_ld1 ? bus.in_re : r_re1;
            r_im1  <= w_ld1 ? bus.in_im : r_im1;
            r_cnt0 <= r_cnt0 + CNT_W'(w_dlv0);
            r_cnt1 <= r_cnt1 + CNT_W'(w_dlv1);
        end
    end

    assign bus.out0_valid = (r_st0 == FULL);
    assign bus.out1_valid = (r_st1 == FULL);
    assign bus.out0_re    = r_re0;
    assign bus.out0_im    = r_im0;
    assign bus.out1_re    = r_re1;
    assign bus.out1_im    = r_im1;
    assign bus.cnt0       = r_cnt0;
    assign bus.cnt1       = r_cnt1;
endmodule

// File: tb/tb_cplx_result_demux.sv
// tb_cplx_result_demux: directed self-checking bench for cplx_result_demux.
module tb_cplx_result_demux;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_tot;

    cplx_result_demux_if #(.W(16), .CNT_W(8)) bus ();

    cplx_result_demux #(.W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [15:0] re, input logic [15:0] im);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_re    = re;
        bus.in_im    = im;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tot++; if (bus.out0_valid !== 1'b0) $display("FAIL reset_out0_valid got=%0h exp=0", bus.out0_valid); else n_pass++;
        n_tot++; if (bus.out1_valid !== 1'b0) $display("FAIL reset_out1_valid got=%0h exp=0", bus.out1_valid); else n_pass++;
        n_tot++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) $display("FAIL reset_cnt got=%0h/%0h exp=0/0", bus.cnt0, bus.cnt1); else n_pass++;
        n_tot++; if (bus.out0_re !== 16'h0 || bus.out1_im !== 16'h0) $display("FAIL reset_data got=%0h/%0h exp=0/0", bus.out0_re, bus.out1_im); else n_pass++;
        n_tot++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.out0_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234, 16'hABCD);
        @(negedge clk);
        n_tot++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        n_tot++; if (bus.out0_valid !== 1'b1) $display("FAIL basic_out0_valid got=%0h exp=1", bus.out0_valid); else n_pass++;
        n_tot++; if (bus.out0_re !== 16'h1234 || bus.out0_im !== 16'hABCD) $display("FAIL basic_data got=%0h/%0h exp=1234/abcd", bus.out0_re, bus.out0_im); else n_pass++;
        n_tot++; if (bus.cnt0 !== 8'd0) $display("FAIL basic_cnt0_pre got=%0d exp=0", bus.cnt0); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (bus.out0_valid !== 1'b0) $display("FAIL basic_out0_drained got=%0h exp=0", bus.out0_valid); else n_pass++;
        n_tot++; if (bus.cnt0 !== 8'd1) $display("FAIL basic_cnt0 got=%0d exp=1", bus.cnt0); else n_pass++;
        n_tot++; if (bus.out1_valid !== 1'b0) $display("FAIL basic_out1_idle got=%0h exp=0", bus.out1_valid); else n_pass++;
    endtask

    task automatic test_stall();
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 16'hA0A0, 16'hA1A1);
        step();
        drive(1'b1, 1'b1, 16'hB0B0, 16'hB1B1);
        @(negedge clk);
        n_tot++; if (bus.out1_valid !== 1'b1) $display("FAIL stall_out1_valid got=%0h exp=1", bus.out1_valid); else n_pass++;
        n_tot++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got=%0h exp=0", bus.in_ready); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (bus.out1_re !== 16'hA0A0 || bus.out1_im !== 16'hA1A1) $display("FAIL stall_hold got=%0h/%0h exp=a0a0/a1a1", bus.out1_re, bus.out1_im); else n_pass++;
        n_tot++; if (bus.cnt1 !== 8'd0) $display("FAIL stall_cnt1 got=%0d exp=0", bus.cnt1); else n_pass++;
    endtask

    task automatic test_no_hol();
        drive(1'b1, 1'b0, 16'hC0C0, 16'hC1C1);
        #1;
        n_tot++; if (bus.in_ready !== 1'b1) $display("FAIL nohol_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
        step();
        drive(1'b1, 1'b1, 16'hB0B0, 16'hB1B1);
        @(negedge clk);
        n_tot++; if (bus.out0_valid !== 1'b1 || bus.out0_re !== 16'hC0C0) $display("FAIL nohol_out0 got=%0h/%0h exp=1/c0c0", bus.out0_valid, bus.out0_re); else n_pass++;
        n_tot++; if (bus.out1_re !== 16'hA0A0) $display("FAIL nohol_out1_hold got=%0h exp=a0a0", bus.out1_re); else n_pass++;
    endtask

    task automatic test_release();
        bus.out1_ready = 1'b1;
        #1;
        n_tot++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        n_tot++; if (bus.out1_valid !== 1'b1 || bus.out1_re !== 16'hB0B0 || bus.out1_im !== 16'hB1B1) $display("FAIL release_reload got=%0h/%0h/%0h exp=1/b0b0/b1b1", bus.out1_valid, bus.out1_re, bus.out1_im); else n_pass++;
        n_tot++; if (bus.cnt1 !== 8'd1) $display("FAIL release_cnt1 got=%0d exp=1", bus.cnt1); else n_pass++;
        n_tot++; if (bus.cnt0 !== 8'd2 || bus.out0_valid !== 1'b0) $display("FAIL release_out0 got=%0d/%0h exp=2/0", bus.cnt0, bus.out0_valid); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (bus.cnt1 !== 8'd2 || bus.out1_valid !== 1'b0) $display("FAIL release_drain got=%0d/%0h exp=2/0", bus.cnt1, bus.out1_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out0_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0100, 16'hF100);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) drive(1'b1, 1'b0, 16'h0101 + 16'(i), 16'hF101 + 16'(i));
            else drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            n_tot++; if (bus.out0_valid !== 1'b1 || bus.out0_re !== 16'h0100 + 16'(i) || bus.out0_im !== 16'hF100 + 16'(i)) $display("FAIL b2b_item%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.out0_valid, bus.out0_re, bus.out0_im, 16'h0100 + 16'(i), 16'hF100 + 16'(i)); else n_pass++;
        end
        step();
        @(negedge clk);
        n_tot++; if (bus.cnt0 !== 8'd5 || bus.out0_valid !== 1'b0) $display("FAIL b2b_cnt0 got=%0d/%0h exp=5/0", bus.cnt0, bus.out0_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bus.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h5555, 16'h6666);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        n_tot++; if (bus.out0_valid !== 1'b1) $display("FAIL midrst_pre got=%0h exp=1", bus.out0_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_tot++; if (bus.out0_valid !== 1'b0 || bus.cnt0 !== 8'd0) $display("FAIL midrst_async got=%0h/%0d exp=0/0", bus.out0_valid, bus.cnt0); else n_pass++;
        n_tot++; if (bus.cnt1 !== 8'd0 || bus.out0_re !== 16'h0) $display("FAIL midrst_clear got=%0d/%0h exp=0/0", bus.cnt1, bus.out0_re); else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        bus.out0_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0777, 16'h0888);
        repeat (255) step();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        @(negedge clk);
        n_tot++; if (bus.cnt0 !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", bus.cnt0); else n_pass++;
        drive(1'b1, 1'b0, 16'h0999, 16'h0AAA);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        @(negedge clk);
        n_tot++; if (bus.cnt0 !== 8'd0 || bus.out0_valid !== 1'b0) $display("FAIL wrap_zero got=%0d/%0h exp=0/0", bus.cnt0, bus.out0_valid); else n_pass++;
        n_tot++; if (bus.cnt1 !== 8'd0) $display("FAIL wrap_cnt1 got=%0d exp=0", bus.cnt1); else n_pass++;
    endtask

    task automatic test_alternate();
        logic sel;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef DEMUX_RR_EN
            sel = 1'b1;
`else
            sel = 1'(i % 2);
`endif
            drive(1'b1, sel, 16'h0200 + 16'(i), 16'h0300 + 16'(i));
            step();
            drive(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            if (i % 2 == 0) begin
                n_tot++; if (bus.out0_valid !== 1'b1 || bus.out0_re !== 16'h0200 + 16'(i) || bus.out1_valid !== 1'b0) $display("FAIL alt_item%0d got=%0h/%0h/%0h exp=1/%0h/0", i, bus.out0_valid, bus.out0_re, bus.out1_valid, 16'h0200 + 16'(i)); else n_pass++;
            end else begin
                n_tot++; if (bus.out1_valid !== 1'b1 || bus.out1_im !== 16'h0300 + 16'(i) || bus.out0_valid !== 1'b0) $display("FAIL alt_item%0d got=%0h/%0h/%0h exp=1/%0h/0", i, bus.out1_valid, bus.out1_im, bus.out0_valid, 16'h0300 + 16'(i)); else n_pass++;
            end
        end
        step();
        @(negedge clk);
        n_tot++; if (bus.cnt0 !== 8'd2 || bus.cnt1 !== 8'd2) $display("FAIL alt_cnt got=%0d/%0d exp=2/2", bus.cnt0, bus.cnt1); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        test_reset();
        test_basic();
        test_stall();
        test_no_hol();
        test_release();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        test_alternate();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
